bit_logic: RTL and testbench
============================

BIT_LOGIC -- requirements
Module: bit_logic

Interface
REQ-001 Parameter: WIDTH, default 16, operand and result width in bits; signed two's-complement.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: in_valid  input  1  operands on in1/in2 are to be captured this cycle.
REQ-005 Port: in1  input  WIDTH (signed)  operand A.
REQ-006 Port: in2  input  WIDTH (signed)  operand B.
REQ-007 Port: and_out  output  WIDTH (signed)  registered in1 AND in2.
REQ-008 Port: or_out  output  WIDTH (signed)  registered in1 OR in2.
REQ-009 Port: xor_out  output  WIDTH (signed)  registered in1 XOR in2.
REQ-010 Port: zero_flags  output  3  registered {xor_out==0, or_out==0, and_out==0}, so bit0 is the AND flag.
REQ-011 Port: out_valid  output  1  results and flags correspond to the most recently accepted operand pair.

Function
REQ-012 Each result bit i SHALL be the named Boolean op of in1[i] and in2[i] for i = 0..WIDTH-1, with no carry, sign extension or cross-bit interaction.
REQ-013 When in_valid=1 at a rising edge, the block SHALL register and_out, or_out, xor_out and zero_flags; they appear on the following cycle (latency 1).
REQ-014 out_valid SHALL be 1 in the cycle after any cycle with in_valid=1, and 0 in the cycle after any cycle with in_valid=0.
REQ-015 When in_valid=0, results and zero_flags SHALL hold their last values.
REQ-016 Back-to-back in_valid=1 SHALL be accepted every cycle (throughput 1/cycle); there is no backpressure.
REQ-017 Operand sign SHALL not affect the result: negative values are treated as raw bit patterns.
REQ-018 zero_flags SHALL be computed from the same-cycle combinational results, not from the previous register contents.
REQ-019 No X SHALL propagate to outputs after reset, whatever the state of in1/in2 when in_valid=0.

Reset
REQ-020 While rst=1 at a rising edge, and_out, or_out and xor_out SHALL clear to 0, zero_flags to 3'b111, and out_valid to 0.
REQ-021 rst SHALL take priority over in_valid; an operand pair presented in the same cycle as reset is discarded.
REQ-022 Reset asserted mid-stream SHALL drop any pending result; the first in_valid after rst deasserts SHALL produce a normal result one cycle later.

Structure
REQ-023 WIDTH default and the zero_flags bit-index constants (FLAG_AND=0, FLAG_OR=1, FLAG_XOR=2) SHALL reside in the shared package bit_logic_pkg.
REQ-024 Combinational bitwise logic SHALL live in one sub-module, bit_logic_core (inputs a, b; outputs and_r, or_r, xor_r, zero[2:0]); bit_logic adds only the registers, valid logic and reset.
REQ-025 The design SHALL be synthesizable with no latches and a single clock domain.

Verification
REQ-026 in1=10, in2=15, in_valid=1 -> next cycle and_out=10, or_out=15, xor_out=5, zero_flags=3'b000, out_valid=1.
REQ-027 in1=25, in2=-30 (0xFFE2) -> and_out=0x0000, or_out=0xFFFB (-5), xor_out=0xFFFB (-5), zero_flags=3'b001.
REQ-028 in1=25, in2=25 -> and_out=25, or_out=25, xor_out=0, zero_flags=3'b100.
REQ-029 Apply the three pairs on consecutive cycles -> three consecutive correct results with out_valid held at 1; then in_valid=0 -> results hold the 25/25 values and out_valid=0.
REQ-030 rst=1 with in_valid=1 and in1=in2=0xFFFF -> next cycle all results 0, zero_flags=3'b111, out_valid=0.
REQ-031 in1=0x8000, in2=0x7FFF -> and_out=0x0000, or_out=0xFFFF, xor_out=0xFFFF (MSB/sign boundary); additionally run a random bitwise compare over at least 1000 pairs.

Source files
------------

// File: rtl/bit_logic_pkg.sv
// Shared constants for the bit_logic block: default operand width and zero_flags bit positions.
// Latency: n/a (constants only).
// Backpressure: n/a.
package bit_logic_pkg;

   localparam int WIDTH_DEF = 16;

   // Bit positions inside zero_flags
   localparam int FLAG_AND  = 0;
   localparam int FLAG_OR   = 1;
   localparam int FLAG_XOR  = 2;
   localparam int NUM_FLAGS = 3;

   // All results are zero after reset, so every zero flag is set
   localparam logic [NUM_FLAGS-1:0] FLAGS_RST = 3'b111;

endpackage

// File: rtl/bit_logic_core.sv
// Purely combinational bitwise AND/OR/XOR of two operands plus per-result zero flags.
// Latency: 0 cycles (combinational).
// Backpressure: none; output follows inputs continuously.
module bit_logic_core
   import bit_logic_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic signed [WIDTH-1:0]     a,
   input  logic signed [WIDTH-1:0]     b,
   output logic signed [WIDTH-1:0]     and_r,
   output logic signed [WIDTH-1:0]     or_r,
   output logic signed [WIDTH-1:0]     xor_r,
   output logic        [NUM_FLAGS-1:0] zero
);

   // Per-bit Boolean ops; sign is irrelevant since no bit influences another
   always_comb begin
      and_r = a & b;
      or_r  = a | b;
      xor_r = a ^ b;
      zero  = '0;
      zero[FLAG_AND] = (and_r == '0);
      zero[FLAG_OR]  = (or_r  == '0);
      zero[FLAG_XOR] = (xor_r == '0);
   end

endmodule

// File: rtl/bit_logic.sv
// Registered bitwise AND/OR/XOR of two signed operands with zero flags and a valid strobe.
// Latency: 1 cycle from in_valid to out_valid; one operand pair accepted every cycle.
// Backpressure: none; results hold their last value while in_valid is low.
module bit_logic
   import bit_logic_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   input  logic signed [WIDTH-1:0]     in1,
   input  logic signed [WIDTH-1:0]     in2,
   output logic signed [WIDTH-1:0]     and_out,
   output logic signed [WIDTH-1:0]     or_out,
   output logic signed [WIDTH-1:0]     xor_out,
   output logic        [NUM_FLAGS-1:0] zero_flags,
   output logic                        out_valid
);

   logic signed [WIDTH-1:0]     and_c;
   logic signed [WIDTH-1:0]     or_c;
   logic signed [WIDTH-1:0]     xor_c;
   logic        [NUM_FLAGS-1:0] zero_c;

   bit_logic_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .a     (in1),
      .b     (in2),
      .and_r (and_c),
      .or_r  (or_c),
      .xor_r (xor_c),
      .zero  (zero_c)
   );

   // Capture results on accepted operands; reset wins over in_valid and drops any pending result.
   // Flags come from the same-cycle combinational results so they always match the captured data.
   always_ff @(posedge clk) begin
      if (rst) begin
         and_out    <= '0;
         or_out     <= '0;
         xor_out    <= '0;
         zero_flags <= FLAGS_RST;
         out_valid  <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            and_out    <= and_c;
            or_out     <= or_c;
            xor_out    <= xor_c;
            zero_flags <= zero_c;
         end
      end
   end

endmodule

// File: tb/tb_bit_logic.sv
// Scoreboard bench for bit_logic: directed vectors plus randomized traffic against a per-bit reference model.
// Stimulus pushes the expected post-edge state of every cycle; a monitor pops and compares after each edge.
module tb_bit_logic;

   localparam int W = 16;

   logic                clk = 1'b0;
   logic                rst;
   logic                in_valid;
   logic signed [W-1:0] in1;
   logic signed [W-1:0] in2;
   logic signed [W-1:0] and_out;
   logic signed [W-1:0] or_out;
   logic signed [W-1:0] xor_out;
   logic        [2:0]   zero_flags;
   logic                out_valid;

   always #5 clk = ~clk;

   bit_logic #(
      .WIDTH (W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in1        (in1),
      .in2        (in2),
      .and_out    (and_out),
      .or_out     (or_out),
      .xor_out    (xor_out),
      .zero_flags (zero_flags),
      .out_valid  (out_valid)
   );

   typedef struct {
      logic         vld;
      logic [W-1:0] e_and;
      logic [W-1:0] e_or;
      logic [W-1:0] e_xor;
      logic [2:0]   e_fl;
      int           id;
   } exp_t;

   exp_t sb[$];
   int   n_chk    = 0;
   int   n_pass   = 0;
   int   n_issued = 0;

   // Reference model state: what the outputs should show after the next edge
   logic [W-1:0] m_and;
   logic [W-1:0] m_or;
   logic [W-1:0] m_xor;
   logic [2:0]   m_fl;

   // Per-bit reference: count of ones at each position decides AND/OR/XOR
   function automatic void model_bits(input logic [W-1:0] a, input logic [W-1:0] b,
                                      output logic [W-1:0] ra, output logic [W-1:0] ro,
                                      output logic [W-1:0] rx);
      ra = '0;
      ro = '0;
      rx = '0;
      for (int i = 0; i < W; i++) begin
         int s;
         s = int'(a[i]) + int'(b[i]);
         ra[i] = (s == 2);
         ro[i] = (s >= 1);
         rx[i] = (s == 1);
      end
   endfunction

   task automatic chk(input string name, input int id, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s #%0d: got %h expected %h", name, id, act, exp);
   endtask

   task automatic push(input logic v, input logic [W-1:0] ea, input logic [W-1:0] eo,
                       input logic [W-1:0] ex, input logic [2:0] ef);
      exp_t e;
      e.vld   = v;
      e.e_and = ea;
      e.e_or  = eo;
      e.e_xor = ex;
      e.e_fl  = ef;
      e.id    = n_issued;
      n_issued++;
      sb.push_back(e);
   endtask

   // Present inputs for one cycle, predict the result with the model, then advance past the edge
   task automatic drive(input logic r, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] ra, ro, rx;
      rst = r; in_valid = v; in1 = a; in2 = b;
      if (r) begin
         m_and = '0; m_or = '0; m_xor = '0; m_fl = 3'b111;
      end else if (v) begin
         model_bits(a, b, ra, ro, rx);
         m_and = ra; m_or = ro; m_xor = rx;
         m_fl  = {rx == '0, ro == '0, ra == '0};
      end
      push(r ? 1'b0 : v, m_and, m_or, m_xor, m_fl);
      @(posedge clk); #1;
   endtask

   // Directed cycle with hand-computed expectations; the model adopts them as its held state
   task automatic drive_lit(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] ea, input logic [W-1:0] eo,
                            input logic [W-1:0] ex, input logic [2:0] ef);
      rst = 1'b0; in_valid = v; in1 = a; in2 = b;
      m_and = ea; m_or = eo; m_xor = ex; m_fl = ef;
      push(v, ea, eo, ex, ef);
      @(posedge clk); #1;
   endtask

   function automatic logic [W-1:0] pick_operand();
      logic [W-1:0] r;
      r = W'($urandom);
      case ($urandom_range(0, 9))
         0: r = '0;
         1: r = '1;
         2: r = 16'h8000;
         3: r = 16'h7FFF;
         default: ;
      endcase
      return r;
   endfunction

   // Monitor: after every edge compare the DUT against the oldest pending expectation
   initial begin
      exp_t e;
      forever begin
         @(posedge clk); #2;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("out_valid",  e.id, W'(out_valid),  W'(e.vld));
            chk("and_out",    e.id, and_out,        e.e_and);
            chk("or_out",     e.id, or_out,         e.e_or);
            chk("xor_out",    e.id, xor_out,        e.e_xor);
            chk("zero_flags", e.id, W'(zero_flags), W'(e.e_fl));
         end
      end
   end

   // Stimulus
   initial begin
      int budget;
      // Reset with a live all-ones operand pair: the pair must be discarded
      drive(1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
      drive(1'b1, 1'b0, 16'h1234, 16'h5678);

      // Three back-to-back pairs, then idle cycles holding the last result
      drive_lit(1'b1, 16'd10, 16'd15,   16'd10,   16'd15,   16'd5,    3'b000);
      drive_lit(1'b1, 16'd25, 16'hFFE2, 16'h0000, 16'hFFFB, 16'hFFFB, 3'b001);
      drive_lit(1'b1, 16'd25, 16'd25,   16'd25,   16'd25,   16'd0,    3'b100);
      drive_lit(1'b0, 16'hDEAD, 16'hBEEF, 16'd25, 16'd25,   16'd0,    3'b100);
      drive_lit(1'b0, 16'h0F0F, 16'hF0F0, 16'd25, 16'd25,   16'd0,    3'b100);

      // Sign boundary and all-zero operands
      drive_lit(1'b1, 16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF, 16'hFFFF, 3'b001);
      drive_lit(1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'b111);
      drive_lit(1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 3'b100);

      // Reset in the middle of a stream, then recovery on the next valid
      drive(1'b0, 1'b1, 16'hA5A5, 16'h5A5A);
      drive(1'b1, 1'b1, 16'h1111, 16'h2222);
      drive(1'b0, 1'b1, 16'hC3C3, 16'h0FF0);
      drive(1'b0, 1'b0, 16'h0000, 16'h0000);

      // Randomized traffic
      for (int k = 0; k < 1500; k++) begin
         drive($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 8, pick_operand(), pick_operand());
      end
      drive(1'b0, 1'b0, 16'h0000, 16'h0000);

      // Let the monitor drain, bounded
      budget = 0;
      while (sb.size() > 0 && budget < 10) begin
         @(posedge clk); #3;
         budget++;
      end
      if (sb.size() > 0) begin
         n_chk++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
